// File: rtl/aes_pkg.sv
// Definitions shared by the AES byte-serial input and output interfaces:
// block geometry, output FSM state encoding and host command codes.
package aes_pkg;

   localparam int DATA_W = 128;
   localparam int BYTE_W = 8;
   localparam int NBYTES = DATA_W / BYTE_W;

   typedef enum logic {
      OS_IDLE = 1'b0,
      OS_SEND = 1'b1
   } os_state_e;

   // Host command codes decoded by the input interface.
   typedef enum logic [1:0] {
      C_ID = 2'b00,
      C_SP = 2'b01,
      C_SK = 2'b10,
      C_ST = 2'b11
   } cmd_e;

endpackage

// File: rtl/output_interface_edge_detect_rise.sv
// One-bit rising-edge detector. The history register resets to RESET_VAL so a
// level already high when reset releases is not mistaken for an edge.
module edge_detect_rise #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst_) begin
         d_q <= RESET_VAL;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/output_interface.sv
// Captures the AES engine ciphertext on the rising edge of its done level and
// streams it out MSB byte first over a valid/ready byte handshake.
module output_interface
   import aes_pkg::*;
#(
   parameter int DATA_W = aes_pkg::DATA_W,
   parameter int BYTE_W = aes_pkg::BYTE_W
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              transformer_done,
   input  logic [DATA_W-1:0] cipher_in,
   output logic [BYTE_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              tx_done,
   output logic              overrun
);

   localparam int NBYTES = DATA_W / BYTE_W;
   localparam int CNT_W  = $clog2(NBYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

   os_state_e         state_q;
   logic [DATA_W-1:0] buf_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [BYTE_W-1:0] dout_q;
   logic              valid_q;
   logic              busy_q;
   logic              tx_done_q;
   logic              overrun_q;

   logic              cap;
   logic              xfer;
   logic              last_xfer;
   logic              load;
   logic [CNT_W-1:0]  cnt_d;
   logic [BYTE_W-1:0] next_byte_d;
   logic [BYTE_W-1:0] first_byte_d;

   function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] blk,
                                                  input logic [CNT_W-1:0]  idx);
      logic [DATA_W-1:0] sh;
      sh = blk << (BYTE_W * idx);
      return sh[DATA_W-1 -: BYTE_W];
   endfunction

   edge_detect_rise #(
      .RESET_VAL (1'b1)
   ) u_done_edge (
      .clk    (clk),
      .rst_   (rst_),
      .d_i    (transformer_done),
      .rise_o (cap)
   );

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      xfer         = (state_q == OS_SEND) & valid_q & dout_ready;
      last_xfer    = xfer & (cnt_q == LAST_IDX);
      // A capture is accepted when idle, or when it coincides with the last byte.
      load         = cap & ((state_q == OS_IDLE) | last_xfer);
      cnt_d        = cnt_q + 1'b1;
      next_byte_d  = byte_of(buf_q, cnt_d);
      first_byte_d = cipher_in[DATA_W-1 -: BYTE_W];
   end

   // NOTE: the ciphertext buffer is an ordinary register, not a memory array,
   // so it is cleared by reset together with the rest of the state.
   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q   <= OS_IDLE;
         buf_q     <= '0;
         cnt_q     <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         tx_done_q <= last_xfer;

         if (load) begin
            state_q <= OS_SEND;
            buf_q   <= cipher_in;
            cnt_q   <= '0;
            dout_q  <= first_byte_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
         end else if (last_xfer) begin
            state_q <= OS_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else if (xfer) begin
            cnt_q  <= cnt_d;
            dout_q <= next_byte_d;
         end

         // Result arriving mid-stream is dropped; flag stays until reset.
         if (cap && (state_q == OS_SEND) && !last_xfer) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign tx_done    = tx_done_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/output_interface.md
Name: output_interface

Overview:
- Downstream neighbour of the AES engine.
- Captures the 128-bit ciphertext when the engine's done level rises, then streams it out as 16 bytes, MSB byte first, over a valid/ready byte handshake.
- Counterpart of the byte-serial input interface: the external host writes bytes in through that interface and reads bytes back through this one.

Parameters:
- DATA_W, 128, width of ciphertext block.
- BYTE_W, 8, width of output byte.
- NBYTES, DATA_W/BYTE_W = 16, bytes per block (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_  in  1  synchronous, active-high reset.
- transformer_done  in  1  AES engine done/idle level; 1 = idle/done, 0 = busy.
- cipher_in  in  DATA_W  engine ciphertext; valid in the cycle transformer_done is sampled rising.
- dout  out  BYTE_W  current output byte.
- dout_valid  out  1  dout holds a valid byte.
- dout_ready  in  1  sink accepts dout this cycle.
- busy  out  1  block is holding or streaming a result.
- tx_done  out  1  one-cycle pulse after the last byte of a block is accepted.
- overrun  out  1  sticky; a new result arrived while the previous one was still streaming.

Behaviour:
- Reset (rst_=1 at an edge): state=IDLE, byte counter=0, buffer=0, dout=0, dout_valid=0, busy=0, tx_done=0, overrun=0. The done_q edge-detect register resets to 1, so a done level held high out of reset is not a capture.
- Reset mid-stream aborts the block; the partial block is discarded with no tx_done.
- Edge detect: cap = transformer_done & ~done_q. done_q <= transformer_done every cycle.
- States:
  - IDLE: dout_valid=0, busy=0. On cap: buffer <= cipher_in, counter <= 0, go to SEND.
  - SEND: busy=1, dout_valid=1, dout = buffer[DATA_W-1-8*counter -: 8], i.e. byte 0 = bits 127:120.
- Latency: cap sampled at edge N gives dout_valid=1 and dout=byte 0 after edge N (visible in cycle N+1).
- Handshake in SEND:
  - A transfer occurs when dout_valid & dout_ready at an edge.
  - dout is stable while valid and not ready.
  - On a transfer the counter increments; dout_ready may be held high for back-to-back bytes, one byte per cycle.
  - Minimum 16 cycles per block.
- Last byte (transfer at counter=NBYTES-1): tx_done=1 for the following cycle, counter wraps to 0, go to IDLE.
- Simultaneous last-byte transfer and cap in the same cycle: capture wins. Reload the buffer, counter=0, stay in SEND, tx_done still pulses, overrun not set.
- cap in SEND when not on the last-byte transfer: new ciphertext is dropped, overrun <= 1, and the current stream continues unaffected.
- overrun is cleared only by reset.
- dout_ready while in IDLE is ignored.
- transformer_done toggling without a rising edge (steady 0 or steady 1) has no effect.

Decomposition:
- Shared package (aes_pkg): DATA_W=128, BYTE_W=8, NBYTES=16; output state encoding OS_IDLE=1'b0, OS_SEND=1'b1. The input interface command codes (C_ID/C_SP/C_SK/C_ST) also move here so both interfaces share one definition.
- One natural sub-module: edge_detect_rise (1-bit rising-edge detector with parameterised reset value, here 1). Buffer, counter and FSM stay in output_interface.

Test Plan:
- Reset/idle: hold transformer_done=1 through and after reset for 10 cycles -> dout_valid=0, busy=0, overrun=0, no capture.
- Basic stream: cipher_in=128'h3925841d02dc09fbdc118597196a0b32, done 1->0->1, dout_ready=1 -> dout_valid rises one cycle after the edge; bytes 39,25,84,1d,02,dc,09,fb,dc,11,85,97,19,6a,0b,32 on 16 consecutive cycles; tx_done pulses once; busy falls.
- Backpressure: same block, dout_ready=0 for 3 cycles on byte 4 and toggling elsewhere -> dout holds 02 while stalled; byte sequence unchanged; no byte duplicated or skipped.
- Overrun: second done edge with cipher_in=128'hFF..FF at byte 7 -> stream continues with the original bytes 7..15; overrun=1 stays high; no second stream follows.
- Back-to-back: second done edge in the same cycle as the last-byte transfer, cipher_in=128'h00112233_44556677_8899aabb_ccddeeff -> tx_done pulses; next cycle dout=00 with valid=1; overrun stays 0.
- Reset mid-stream: assert rst_ at byte 5 -> next cycle dout_valid=0, dout=0, busy=0, no tx_done; a later done edge starts at byte 0.
